// File: rtl/tcam_pri_pkg.sv
// Shared definitions for the ternary CAM: write FSM encoding, depth helper
// and the lowest-index priority encoder.
package tcam_pri_pkg;

    localparam int unsigned MAX_ADDR_WIDTH = 8;
    localparam int unsigned MAX_ENTRY_NUM  = 32'd1 << MAX_ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    function automatic int unsigned entry_num(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // Scans from the top down so the lowest set index is the last one written.
    function automatic int unsigned lowest_set(input logic [MAX_ENTRY_NUM-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = MAX_ENTRY_NUM; i > 0; i--) begin
            if (vec[i-1]) idx = i - 1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/tcam_pri_enc.sv
// Combinational result encoder: any-hit, lowest hit index, two-or-more hits.
module tcam_pri_enc
    import tcam_pri_pkg::*;
#(
    parameter  int unsigned C_TCAM_ADDR_WIDTH = 5,
    localparam int unsigned ENTRY_NUM         = entry_num(C_TCAM_ADDR_WIDTH)
) (
    input  logic [ENTRY_NUM-1:0]         hit,
    output logic                         match,
    output logic [C_TCAM_ADDR_WIDTH-1:0] addr,
    output logic                         multi
);

    logic [MAX_ENTRY_NUM-1:0] hit_ext;

    always_comb begin
        hit_ext                = '0;
        hit_ext[ENTRY_NUM-1:0] = hit;
    end

    assign match = |hit;
    assign addr  = C_TCAM_ADDR_WIDTH'(lowest_set(hit_ext));
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(hit & (hit - ENTRY_NUM'(1)));

endmodule

// File: rtl/tcam_pri.sv
// Register-based ternary CAM with per-entry valid bits, 2-cycle write/clear
// FSM and a 2-stage lookup pipeline resolving the lowest matching index.
module tcam_pri
    import tcam_pri_pkg::*;
#(
    parameter int unsigned C_TCAM_ADDR_WIDTH = 5,
    parameter int unsigned C_TCAM_DATA_WIDTH = 32
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic                         WE,
    input  logic [C_TCAM_ADDR_WIDTH-1:0] ADDR_WR,
    input  logic [C_TCAM_DATA_WIDTH-1:0] DIN,
    input  logic [C_TCAM_DATA_WIDTH-1:0] DIN_MASK,
    input  logic                         DIN_VALID,
    input  logic                         CLR,
    output logic                         BUSY,
    input  logic                         CMP_REQ,
    input  logic [C_TCAM_DATA_WIDTH-1:0] CMP_DIN,
    output logic                         MATCH_VALID,
    output logic                         MATCH,
    output logic [C_TCAM_ADDR_WIDTH-1:0] MATCH_ADDR,
    output logic                         MULTI_MATCH
);

    localparam int unsigned A = C_TCAM_ADDR_WIDTH;
    localparam int unsigned D = C_TCAM_DATA_WIDTH;
    localparam int unsigned N = entry_num(A);

    logic [1:0]   state;
    logic [A-1:0] wr_addr;
    logic [D-1:0] wr_key;
    logic [D-1:0] wr_mask;
    logic         wr_valid;

    logic [N-1:0] valid;
    logic [D-1:0] key_mem  [N];
    logic [D-1:0] mask_mem [N];

    logic [N-1:0] hit;
    logic         s1_vld;
    logic [N-1:0] s1_hit;
    logic         enc_match;
    logic [A-1:0] enc_addr;
    logic         enc_multi;

    assign BUSY = (state != ST_IDLE);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= ST_IDLE;
            valid <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (CLR)     state <= ST_CLEAR;
                    else if (WE) state <= ST_WRITE;
                end
                ST_WRITE: begin
                    valid[wr_addr] <= wr_valid;
                    state          <= ST_IDLE;
                end
                ST_CLEAR: begin
                    valid <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Key/mask storage and the write staging registers carry no reset.
    always_ff @(posedge CLK) begin
        if (state == ST_IDLE && WE && !CLR) begin
            wr_addr  <= ADDR_WR;
            wr_key   <= DIN & ~DIN_MASK;
            wr_mask  <= DIN_MASK;
            wr_valid <= DIN_VALID;
        end
        if (state == ST_WRITE) begin
            key_mem[wr_addr]  <= wr_key;
            mask_mem[wr_addr] <= wr_mask;
        end
    end

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < N; i++) begin
            hit[i] = valid[i] & (((key_mem[i] ^ CMP_DIN) & ~mask_mem[i]) == '0);
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            s1_vld <= 1'b0;
            s1_hit <= '0;
        end else begin
            s1_vld <= CMP_REQ;
            s1_hit <= CMP_REQ ? hit : '0;
        end
    end

    tcam_pri_enc #(
        .C_TCAM_ADDR_WIDTH(A)
    ) u_enc (
        .hit  (s1_hit),
        .match(enc_match),
        .addr (enc_addr),
        .multi(enc_multi)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            MATCH_VALID <= 1'b0;
            MATCH       <= 1'b0;
            MATCH_ADDR  <= '0;
            MULTI_MATCH <= 1'b0;
        end else begin
            MATCH_VALID <= s1_vld;
            MATCH       <= s1_vld & enc_match;
            MATCH_ADDR  <= s1_vld ? enc_addr : '0;
            MULTI_MATCH <= s1_vld & enc_multi;
        end
    end

endmodule

// File: tb/tb_tcam_pri.sv
// Self-checking bench for tcam_pri: directed scenarios with literal
// expectations plus randomized traffic against a table-level model.
module tb_tcam_pri;

    localparam int unsigned A = 5;
    localparam int unsigned D = 32;
    localparam int unsigned N = 32;

    logic         CLK = 1'b0;
    logic         RSTN = 1'b0;
    logic         WE = 1'b0;
    logic [A-1:0] ADDR_WR = '0;
    logic [D-1:0] DIN = '0;
    logic [D-1:0] DIN_MASK = '0;
    logic         DIN_VALID = 1'b0;
    logic         CLR = 1'b0;
    logic         BUSY;
    logic         CMP_REQ = 1'b0;
    logic [D-1:0] CMP_DIN = '0;
    logic         MATCH_VALID;
    logic         MATCH;
    logic [A-1:0] MATCH_ADDR;
    logic         MULTI_MATCH;

    always #5 CLK = ~CLK;

    tcam_pri #(
        .C_TCAM_ADDR_WIDTH(A),
        .C_TCAM_DATA_WIDTH(D)
    ) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .WE         (WE),
        .ADDR_WR    (ADDR_WR),
        .DIN        (DIN),
        .DIN_MASK   (DIN_MASK),
        .DIN_VALID  (DIN_VALID),
        .CLR        (CLR),
        .BUSY       (BUSY),
        .CMP_REQ    (CMP_REQ),
        .CMP_DIN    (CMP_DIN),
        .MATCH_VALID(MATCH_VALID),
        .MATCH      (MATCH),
        .MATCH_ADDR (MATCH_ADDR),
        .MULTI_MATCH(MULTI_MATCH)
    );

    typedef struct packed {
        logic         v;
        logic         m;
        logic [A-1:0] a;
        logic         mm;
    } res_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Table contents as seen by lookups, plus the one operation waiting to commit.
    logic [D-1:0] mkey  [N];
    logic [D-1:0] mmask [N];
    logic         mvalid[N];
    logic         m_busy;
    logic         pend_wr, pend_clr;
    logic [A-1:0] p_a;
    logic [D-1:0] p_k, p_m;
    logic         p_v;
    res_t         pipe1, exp_out;

    function automatic res_t lookup(input logic [D-1:0] k);
        res_t r;
        int   hits;
        r    = '0;
        r.v  = 1'b1;
        hits = 0;
        for (int i = 0; i < N; i++) begin
            if (mvalid[i] && (((mkey[i] ^ k) & ~mmask[i]) == '0)) begin
                if (hits == 0) r.a = A'(i);
                hits++;
            end
        end
        r.m  = (hits > 0);
        r.mm = (hits > 1);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mvalid[i] = 1'b0;
        m_busy   = 1'b0;
        pend_wr  = 1'b0;
        pend_clr = 1'b0;
        pipe1    = '0;
        exp_out  = '0;
    endtask

    task automatic model_step(input logic we, input logic [A-1:0] a, input logic [D-1:0] d,
                              input logic [D-1:0] m, input logic dv, input logic clr,
                              input logic req, input logic [D-1:0] ck);
        res_t r;
        r = req ? lookup(ck) : '0;
        if (m_busy) begin
            if (pend_wr) begin
                mkey[p_a]   = p_k;
                mmask[p_a]  = p_m;
                mvalid[p_a] = p_v;
            end
            if (pend_clr) for (int i = 0; i < N; i++) mvalid[i] = 1'b0;
            pend_wr  = 1'b0;
            pend_clr = 1'b0;
            m_busy   = 1'b0;
        end else if (clr) begin
            pend_clr = 1'b1;
            m_busy   = 1'b1;
        end else if (we) begin
            pend_wr = 1'b1;
            p_a     = a;
            p_k     = d & ~m;
            p_m     = m;
            p_v     = dv;
            m_busy  = 1'b1;
        end
        exp_out = pipe1;
        pipe1   = r;
    endtask

    task automatic compare();
        res_t got;
        got = {MATCH_VALID, MATCH, MATCH_ADDR, MULTI_MATCH};
        n_tests++;
        if (got !== exp_out || BUSY !== m_busy) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t: got v=%0b m=%0b a=%0d mm=%0b busy=%0b, want v=%0b m=%0b a=%0d mm=%0b busy=%0b",
                     $time, got.v, got.m, got.a, got.mm, BUSY,
                     exp_out.v, exp_out.m, exp_out.a, exp_out.mm, m_busy);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic cycle(input logic we, input logic [A-1:0] a, input logic [D-1:0] d,
                         input logic [D-1:0] m, input logic dv, input logic clr,
                         input logic req, input logic [D-1:0] ck);
        WE = we; ADDR_WR = a; DIN = d; DIN_MASK = m; DIN_VALID = dv;
        CLR = clr; CMP_REQ = req; CMP_DIN = ck;
        model_step(we, a, d, m, dv, clr, req, ck);
        @(posedge CLK);
        @(negedge CLK);
        compare();
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic wr(input logic [A-1:0] a, input logic [D-1:0] k, input logic [D-1:0] m,
                      input logic v);
        cycle(1'b1, a, k, m, v, 1'b0, 1'b0, '0);
        lit("wr_busy_hi", BUSY, 1);
        idle();
        lit("wr_busy_lo", BUSY, 0);
    endtask

    task automatic look(input logic [D-1:0] k);
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, k);
        idle();
    endtask

    task automatic check_result(input string name, input logic m, input logic [A-1:0] a,
                                input logic mm);
        lit({name, "_mv"}, MATCH_VALID, 1);
        lit({name, "_m"}, MATCH, 32'(m));
        lit({name, "_a"}, 32'(MATCH_ADDR), 32'(a));
        lit({name, "_mm"}, MULTI_MATCH, 32'(mm));
    endtask

    task automatic check_all_zero(input string name);
        lit(name, {BUSY, MATCH_VALID, MATCH, MULTI_MATCH, 32'(MATCH_ADDR)}, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge CLK);
        check_all_zero("reset_outputs");
        RSTN = 1'b1;
        idle();

        // Exact match with exact 2-cycle latency
        wr(5'd0, 32'h12341234, 32'h0, 1'b1);
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 32'h12341234);
        lit("lat_n1_mv", MATCH_VALID, 0);
        idle();
        check_result("exact", 1'b1, 5'd0, 1'b0);
        look(32'h12341235);
        check_result("exact_miss", 1'b0, 5'd0, 1'b0);

        // Ternary and priority
        wr(5'd15, 32'hABCD0000, 32'h0000FFFF, 1'b1);
        wr(5'd30, 32'hABCD5678, 32'h0, 1'b1);
        look(32'hABCD5678);
        check_result("prio_multi", 1'b1, 5'd15, 1'b1);
        look(32'hABCD1111);
        check_result("ternary", 1'b1, 5'd15, 1'b0);

        // Delete and clear
        wr(5'd15, 32'h0, 32'h0, 1'b0);
        look(32'hABCD5678);
        check_result("after_del", 1'b1, 5'd30, 1'b0);
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
        lit("clr_busy_hi", BUSY, 1);
        idle();
        lit("clr_busy_lo", BUSY, 0);
        look(32'hABCD5678);
        check_result("after_clr", 1'b0, 5'd0, 1'b0);

        // Busy and coherency: second WE dropped, WRITE-cycle lookup sees old table
        cycle(1'b1, 5'd3, 32'h00005555, 32'h0, 1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 5'd4, 32'h0000AAAA, 32'h0, 1'b1, 1'b0, 1'b1, 32'h00005555);
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 32'h00005555);
        check_result("in_write", 1'b0, 5'd0, 1'b0);
        idle();
        check_result("after_busy", 1'b1, 5'd3, 1'b0);
        look(32'h0000AAAA);
        check_result("second_we", 1'b0, 5'd0, 1'b0);

        // WE with CLR: table cleared, write dropped
        cycle(1'b1, 5'd5, 32'h00007777, 32'h0, 1'b1, 1'b1, 1'b0, '0);
        idle();
        look(32'h00007777);
        check_result("we_clr_k3", 1'b0, 5'd0, 1'b0);
        look(32'h00005555);
        check_result("we_clr_k1", 1'b0, 5'd0, 1'b0);

        // Throughput: 8 back-to-back lookups
        for (int i = 0; i < 8; i++) wr(A'(i), 32'h100 + 32'(i), 32'h0, 1'b1);
        for (int j = 0; j <= 8; j++) begin
            cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, (j < 8), 32'h100 + 32'(j));
            if (j > 0) check_result("stream", 1'b1, A'(j - 1), 1'b0);
        end

        // Reset mid-stream with a write in flight
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 32'h100);
        cycle(1'b1, 5'd7, 32'h00009999, 32'h0, 1'b1, 1'b0, 1'b1, 32'h101);
        CMP_REQ = 1'b1;
        CMP_DIN = 32'h102;
        WE = 1'b0;
        #2 RSTN = 1'b0;
        #1 check_all_zero("async_reset");
        model_reset();
        @(negedge CLK);
        check_all_zero("held_reset");
        CMP_REQ = 1'b0;
        RSTN = 1'b1;
        idle();
        idle();
        look(32'h00009999);
        check_result("lost_write", 1'b0, 5'd0, 1'b0);
        look(32'h103);
        check_result("post_rst_inv", 1'b0, 5'd0, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic         we, clr, req, dv;
            logic [A-1:0] a;
            logic [D-1:0] k, m, ck;
            we  = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 39) == 0);
            req = $urandom_range(0, 1);
            dv  = ($urandom_range(0, 4) != 0);
            a   = A'($urandom_range(0, N - 1));
            k   = 32'hC0DE0000 | ($urandom & 32'hF);
            case ($urandom_range(0, 3))
                0:       m = 32'h0;
                1:       m = 32'hF;
                2:       m = $urandom & 32'hF;
                default: m = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'h3;
            endcase
            ck = ($urandom_range(0, 9) == 0) ? $urandom : (32'hC0DE0000 | ($urandom & 32'hF));
            cycle(we, a, k, m, dv, clr, req, ck);
        end
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tcam_pri.md
Name: tcam_pri

Overview:
- Parametrised successor to the team's binary match CAM, built for lookup tables in the datapath (filter and forwarding keys).
- Adds per-entry ternary masks, per-entry valid bits, entry delete and global clear.
- Adds an explicit lookup request with a result-valid strobe, lowest-index priority resolution and a multi-match flag.
- Register-based storage: depth 2**C_TCAM_ADDR_WIDTH, fixed 2-cycle lookup pipeline, fixed 2-cycle write with BUSY.

Parameters:
- C_TCAM_ADDR_WIDTH  5   log2 of entry count (depth 32 by default).
- C_TCAM_DATA_WIDTH  32  key width in bits; legal range 1..128.

Ports:
- CLK          in   1    single clock; all logic on rising edge.
- RSTN         in   1    asynchronous, active-low reset.
- WE           in   1    write/delete request; sampled only while BUSY=0.
- ADDR_WR      in   A    entry index to write.
- DIN          in   D    key to store.
- DIN_MASK     in   D    1 = don't-care bit for this entry.
- DIN_VALID    in   1    1 = install entry, 0 = delete entry.
- CLR          in   1    invalidate all entries; sampled only while BUSY=0.
- BUSY         out  1    high while a write or clear commits.
- CMP_REQ      in   1    lookup request strobe; accepted every cycle, BUSY has no effect.
- CMP_DIN      in   D    lookup key.
- MATCH_VALID  out  1    result strobe, 2 cycles after CMP_REQ.
- MATCH        out  1    at least one valid entry hit.
- MATCH_ADDR   out  A    lowest hit index; 0 when MATCH=0.
- MULTI_MATCH  out  1    two or more entries hit.

Behaviour:
- Reset (RSTN=0, async): all entry valid bits cleared, FSM to IDLE, both pipeline stages cleared. Every output is 0. Key and mask storage need no reset.
- Write FSM states:
  - IDLE: BUSY=0.
  - IDLE->WRITE on WE=1 and CLR=0. Latch ADDR_WR, DIN & ~DIN_MASK, DIN_MASK, DIN_VALID.
  - IDLE->CLEAR on CLR=1. CLR wins over WE, and WE in that cycle is dropped (no queueing).
  - WRITE: BUSY=1 for exactly one cycle. Entry key/mask/valid are updated on the edge ending WRITE, then -> IDLE.
  - CLEAR: BUSY=1 for one cycle. All valid bits are cleared on the edge ending CLEAR, then -> IDLE.
  - WE or CLR asserted while BUSY=1 is ignored. Back-to-back writes therefore sustain 1 write per 2 cycles.
- Delete (DIN_VALID=0): clears only the valid bit; key and mask are don't-care afterwards.
- Hit rule: hit[i] = valid[i] & (((key[i] ^ CMP_DIN) & ~mask[i]) == 0). An entry with an all-ones mask matches any key.
- Lookup pipeline:
  - Stage 1: on the edge where CMP_REQ=1, register the hit vector and set s1_vld. When CMP_REQ=0, s1_vld=0.
  - Stage 2: priority encode with lowest index winning, detect popcount>=2, register MATCH, MATCH_ADDR, MULTI_MATCH and MATCH_VALID.
  - Latency: CMP_REQ in cycle N gives MATCH_VALID=1 in cycle N+2. Throughput is 1 lookup per cycle.
  - When MATCH_VALID=0, MATCH, MATCH_ADDR and MULTI_MATCH are all forced to 0.
- Coherency: a lookup sampled in any cycle with BUSY=1 (including the WRITE cycle) sees the old table. A lookup sampled in the cycle after BUSY falls sees the new table.
- Reset mid-operation: a pending write is lost, in-flight lookups are discarded, and MATCH_VALID is 0 for 2 cycles after RSTN rises.

Decomposition:
- Package tcam_pri_pkg holds:
  - the FSM state encoding (IDLE, WRITE, CLEAR);
  - an ENTRY_NUM = 2**C_TCAM_ADDR_WIDTH helper;
  - a priority-encode function returning the lowest set index.
- One sub-module, tcam_pri_enc:
  - input: registered hit vector;
  - output: match, addr, multi;
  - purely combinational, instantiated inside stage 2.

Test Plan (defaults A=5, D=32):
- Exact match: write idx 0 key 32'h12341234 mask 0. Lookup 32'h12341234 -> MATCH_VALID=1, MATCH=1, MATCH_ADDR=0, MULTI_MATCH=0, exactly 2 cycles after CMP_REQ. Lookup 32'h12341235 -> MATCH=0.
- Ternary and priority:
  - Setup: idx 15 key 32'hABCD0000 mask 32'h0000FFFF; idx 30 key 32'hABCD5678 mask 0.
  - Lookup 32'hABCD5678 -> MATCH_ADDR=15, MULTI_MATCH=1.
  - Lookup 32'hABCD1111 -> MATCH_ADDR=15, MULTI_MATCH=0.
- Delete and clear:
  - Delete idx 15, then lookup 32'hABCD5678 -> MATCH_ADDR=30.
  - CLR, then the same lookup -> MATCH=0.
  - Confirm BUSY high exactly one cycle each time.
- Busy and coherency:
  - WE held 2 consecutive cycles -> only the first is accepted.
  - A lookup in the WRITE cycle misses the new key.
  - A lookup in the cycle after BUSY falls hits it.
  - WE and CLR in the same cycle -> table cleared, write dropped.
- Throughput and reset:
  - CMP_REQ every cycle for 8 different keys -> 8 consecutive MATCH_VALID results in order.
  - RSTN pulsed mid-stream -> all outputs 0 immediately, all entries invalid afterwards.
